wb_uart_bridge: RTL and testbench
=================================

// Module: wb_uart_bridge
// PURPOSE
// - Host-driven Wishbone bus initiator that is fed by the uart byte interface.
// - Parses read/write command frames from rx bytes, runs one bus cycle on the WB_intercon master port, and returns the reply through tx.
// - Gives the host debug/load access to Ram, VRam, Disk and Counter slaves while the CPU clock is gated off.
// PARAMETERS
// - TIMEOUT_CYCLES  1024   clk cycles STB may wait for ACK before abort; must be >= 2.
// - RSP_OK          8'h4B  write-complete reply byte ('K').
// - RSP_TMO         8'hEE  bus-timeout reply byte.
// - RSP_BAD         8'h3F  unknown-opcode reply byte ('?').
// PORTS
// - clk      in   1   single clock (clk100 domain); all logic on posedge.
// - rstn     in   1   reset, asynchronous, active-low.
// - rx_done  in   1   one-cycle pulse: rx_data valid.
// - rx_data  in   8   received byte.
// - tx_busy  in   1   transmitter shifting.
// - tx_done  in   1   one-cycle pulse: byte fully sent.
// - tx_en    out  1   one-cycle pulse: load tx_data into the transmitter.
// - tx_data  out  8   byte to send; stable from tx_en until tx_done.
// - STB      out  1   Wishbone strobe (single master request).
// - WE       out  1   1 = write, 0 = read; valid while STB is high.
// - ADDR     out 32   byte address; valid while STB is high.
// - DAT_O    out 32   write data.
// - DAT_I    in  32   read data; sampled on the ACK cycle.
// - ACK      in   1   slave acknowledge.
// - busy     out  1   high in any state other than IDLE.
// - err_cnt  out  8   saturating count of timeouts plus bad opcodes (and checksum failures when enabled).
// BEHAVIOUR
// - Reset (async, rstn low) drives all outputs to 0, returns the FSM to IDLE, and clears err_cnt.
// - STB drops in the same instant as reset, even mid-cycle.
// - Command frame, all multi-byte fields MSB first:
//   - 0x57 'W' + ADDR[4] + DATA[4]
//   - 0x52 'R' + ADDR[4]
// - FSM states:
//   - IDLE: an rx byte of 0x57 or 0x52 latches op and goes to ADDR. Any other byte sends RSP_BAD, increments err_cnt, and goes to RESP.
//   - ADDR: shift 4 bytes into ADDR. Then W goes to DATA, R goes to BUS.
//   - DATA: shift 4 bytes into DAT_O, then go to BUS.
//   - BUS: STB=1 and WE=op_is_W on the first BUS cycle. Hold until ACK; that cycle latches DAT_I and goes to RESP, with STB=0 on the next cycle.
//   - BUS timeout: if TIMEOUT_CYCLES elapse without ACK, drop STB, queue RSP_TMO, increment err_cnt, and go to RESP.
//   - RESP: send the queued bytes, then return to IDLE. W reply = RSP_OK. R reply = 4 latched data bytes, MSB first.
// - Tx handshake: pulse tx_en for one cycle only when tx_busy=0. Wait for tx_done before issuing the next byte.
// - Boundary conditions:
//   - ACK and timeout on the same cycle: ACK wins; no error.
//   - rx_done during BUS or RESP: the byte is dropped.
//   - ACK while STB=0: ignored.
//   - err_cnt saturates at 8'hFF.
//   - The address is not alignment-checked; ADDR[1:0] passes through.
// - Latency: the last command byte's rx_done -> STB high on the next cycle.
// CONFIGURATION
// - WB_BRIDGE_CKSUM_EN defined:
//   - Each command carries a trailing XOR-of-all-prior-bytes checksum; a CKSUM state follows the last field.
//   - On mismatch: no bus cycle, send RSP_BAD, increment err_cnt.
//   - Replies append the XOR of their own bytes.
// - WB_BRIDGE_CKSUM_EN undefined: no checksum byte on either direction; the CKSUM state is absent.
// STRUCTURE
// - Shared package holds: the state encoding localparams, the opcode constants 0x57/0x52, and the reply-byte defaults.
// - One sub-module: wb_uart_bridge_txq, a 5-entry reply byte queue.
//   - Loaded in parallel from the FSM.
//   - Owns the tx_en/tx_busy/tx_done handshake and raises empty when drained.
// - The FSM, byte shifters, and timeout counter (width $clog2(TIMEOUT_CYCLES+1)) live in the top module.
// TESTING
// - Write path:
//   - Stimulus: rx 57 00 00 10 04 DE AD BE EF.
//   - Required: one STB pulse with WE=1, ADDR=0x00001004, DAT_O=0xDEADBEEF; after ACK, tx sends 4B and busy falls.
// - Read path:
//   - Stimulus: rx 52 00 00 00 08; slave ACKs after 3 cycles with DAT_I=0x12345678.
//   - Required: tx sends 12 34 56 78.
// - Timeout:
//   - Stimulus: rx 52 + address; ACK held 0.
//   - Required: STB high for exactly 1024 cycles, then EE sent, err_cnt=1.
// - Bad opcode:
//   - Stimulus: rx 41.
//   - Required: tx 3F, err_cnt increments, no STB.
// - Reset mid-BUS:
//   - Stimulus: rstn=0 while STB=1.
//   - Required: STB=0 asynchronously, busy=0, err_cnt=0; a following valid frame completes normally.
// - Checksum (WB_BRIDGE_CKSUM_EN):
//   - Stimulus: rx 52 00 00 00 00 with a wrong checksum.
//   - Required: 3F sent, no STB.
//   - Stimulus: the same frame with checksum 52.
//   - Required: the read reply is followed by the correct XOR byte.

Source files
------------

// File: rtl/wb_uart_bridge_pkg.sv
// Shared constants, state encoding and byte helpers for the UART-to-Wishbone bridge.
// The WB_BRIDGE_CKSUM_EN macro adds the CKSUM state to the encoding.
package wb_uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] RSP_OK_DEF  = 8'h4B;
  localparam logic [7:0] RSP_TMO_DEF = 8'hEE;
  localparam logic [7:0] RSP_BAD_DEF = 8'h3F;

  localparam int TXQ_DEPTH = 5;

  localparam logic [2:0] ST_IDLE_C  = 3'd0;
  localparam logic [2:0] ST_ADDR_C  = 3'd1;
  localparam logic [2:0] ST_DATA_C  = 3'd2;
  localparam logic [2:0] ST_CKSUM_C = 3'd3;
  localparam logic [2:0] ST_BUS_C   = 3'd4;
  localparam logic [2:0] ST_RESP_C  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_ADDR  = ST_ADDR_C,
    ST_DATA  = ST_DATA_C,
`ifdef WB_BRIDGE_CKSUM_EN
    ST_CKSUM = ST_CKSUM_C,
`endif
    ST_BUS   = ST_BUS_C,
    ST_RESP  = ST_RESP_C
  } state_e;

  typedef logic [TXQ_DEPTH-1:0][7:0] txq_bytes_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // XOR of the first n bytes of a reply image
  function automatic logic [7:0] xor_bytes(input txq_bytes_t b, input logic [2:0] n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < TXQ_DEPTH; i++) begin
      if (i < int'(n)) begin
        x = x ^ b[i];
      end else begin
        x = x;
      end
    end
    return x;
  endfunction

endpackage

// File: rtl/wb_uart_bridge_txq.sv
// Reply byte queue: parallel-loaded by the bridge FSM, drains one byte at a time
// through the transmitter's tx_en / tx_busy / tx_done handshake.
module wb_uart_bridge_txq
  import wb_uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  txq_bytes_t load_data_i,
  input  logic [2:0] load_cnt_i,
  input  logic       tx_busy_i,
  input  logic       tx_done_i,
  output logic       tx_en_o,
  output logic [7:0] tx_data_o,
  output logic       empty_o
);

  txq_bytes_t buf_q, buf_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] rd_q, rd_d;
  logic       wait_q, wait_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       empty_q, empty_d;

  // Queue state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q     <= '0;
      cnt_q     <= 3'd0;
      rd_q      <= 3'd0;
      wait_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      empty_q   <= 1'b1;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wait_q    <= wait_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      empty_q   <= empty_d;
    end
  end

  // A byte stays counted until its tx_done, so empty means fully sent
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wait_d    = wait_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    if (load_i) begin
      buf_d  = load_data_i;
      cnt_d  = load_cnt_i;
      rd_d   = 3'd0;
      wait_d = 1'b0;
    end else if (wait_q) begin
      if (tx_done_i) begin
        wait_d = 1'b0;
        cnt_d  = cnt_q - 3'd1;
        rd_d   = rd_q + 3'd1;
      end else begin
        wait_d = 1'b1;
      end
    end else if ((cnt_q != 3'd0) && !tx_busy_i) begin
      tx_en_d   = 1'b1;
      tx_data_d = buf_q[rd_q];
      wait_d    = 1'b1;
    end else begin
      tx_en_d = 1'b0;
    end
    empty_d = (cnt_d == 3'd0);
  end

  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/wb_uart_bridge.sv
// Host-driven Wishbone initiator: parses UART command frames, runs one bus cycle, replies via tx.
// Optional trailing XOR checksums on commands and replies with `define WB_BRIDGE_CKSUM_EN.
module wb_uart_bridge
  import wb_uart_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] RSP_OK         = RSP_OK_DEF,
  parameter logic [7:0] RSP_TMO        = RSP_TMO_DEF,
  parameter logic [7:0] RSP_BAD        = RSP_BAD_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADDR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    cks_q, cks_d;
  logic          busy_q, busy_d;

  logic          start_bus_s;
  logic          reply_bad_s;
  logic          q_load_s;
  txq_bytes_t    q_data_s;
  logic [2:0]    q_cnt_s;
  logic          q_empty_s;

  // FSM and datapath registers; STB falls with rstn even mid-cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= 32'h0;
      wdat_q     <= 32'h0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      tmo_cnt_q  <= '0;
      err_q      <= 8'h00;
      cks_q      <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      cks_q      <= cks_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, field shifters, bus timeout and reply assembly
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    stb_d       = stb_q;
    we_d        = we_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    cks_d       = cks_q;
    start_bus_s = 1'b0;
    reply_bad_s = 1'b0;
    q_load_s    = 1'b0;
    q_data_s    = '0;
    q_cnt_s     = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
            is_wr_d    = (rx_data == OP_WRITE);
            byte_cnt_d = 2'd0;
            cks_d      = rx_data;
            state_d    = ST_ADDR;
          end else begin
            reply_bad_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          addr_d     = {addr_q[23:0], rx_data};
          cks_d      = cks_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
`ifdef WB_BRIDGE_CKSUM_EN
              state_d = ST_CKSUM;
`else
              start_bus_s = 1'b1;
`endif
            end
          end else begin
            state_d = ST_ADDR;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          wdat_d     = {wdat_q[23:0], rx_data};
          cks_d      = cks_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
`ifdef WB_BRIDGE_CKSUM_EN
            state_d = ST_CKSUM;
`else
            start_bus_s = 1'b1;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef WB_BRIDGE_CKSUM_EN
      ST_CKSUM: begin
        if (rx_done) begin
          if (rx_data == cks_q) begin
            start_bus_s = 1'b1;
          end else begin
            reply_bad_s = 1'b1;
          end
        end else begin
          state_d = ST_CKSUM;
        end
      end
`endif
      ST_BUS: begin
        // ACK takes priority over a timeout expiring in the same cycle
        if (ACK && stb_q) begin
          stb_d    = 1'b0;
          we_d     = 1'b0;
          q_load_s = 1'b1;
          if (is_wr_q) begin
            q_data_s[0] = RSP_OK;
            q_cnt_s     = 3'd1;
          end else begin
            q_data_s[0] = DAT_I[31:24];
            q_data_s[1] = DAT_I[23:16];
            q_data_s[2] = DAT_I[15:8];
            q_data_s[3] = DAT_I[7:0];
            q_cnt_s     = 3'd4;
          end
          state_d = ST_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          stb_d       = 1'b0;
          we_d        = 1'b0;
          err_d       = sat_inc8(err_q);
          q_load_s    = 1'b1;
          q_data_s[0] = RSP_TMO;
          q_cnt_s     = 3'd1;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (q_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    if (start_bus_s) begin
      state_d   = ST_BUS;
      stb_d     = 1'b1;
      we_d      = is_wr_q;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_d;
    end

    if (reply_bad_s) begin
      err_d       = sat_inc8(err_q);
      q_load_s    = 1'b1;
      q_data_s[0] = RSP_BAD;
      q_cnt_s     = 3'd1;
      state_d     = ST_RESP;
    end else begin
      err_d = err_d;
    end

`ifdef WB_BRIDGE_CKSUM_EN
    if (q_load_s) begin
      q_data_s[q_cnt_s] = xor_bytes(q_data_s, q_cnt_s);
      q_cnt_s           = q_cnt_s + 3'd1;
    end else begin
      q_cnt_s = 3'd0;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  wb_uart_bridge_txq u_txq (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (q_load_s),
    .load_data_i (q_data_s),
    .load_cnt_i  (q_cnt_s),
    .tx_busy_i   (tx_busy),
    .tx_done_i   (tx_done),
    .tx_en_o     (tx_en),
    .tx_data_o   (tx_data),
    .empty_o     (q_empty_s)
  );

  assign STB     = stb_q;
  assign WE      = we_q;
  assign ADDR    = addr_q;
  assign DAT_O   = wdat_q;
  assign busy    = busy_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Self-checking bench for wb_uart_bridge: expected tx bytes are queued when a frame is
// driven and popped by the transmitter model as the bridge emits them.
module tb_wb_uart_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I = 32'h0;
  logic        ACK = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          exp_err = 0;

  int          ack_delay = 0;
  logic [31:0] rd_data = 32'h0;
  int          scnt = 0;

  int          stb_cycles = 0;
  int          stb_pulses = 0;
  logic        stb_prev = 1'b0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_dat = 32'h0;

  wb_uart_bridge dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_done (rx_done),
    .rx_data (rx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .STB     (STB),
    .WE      (WE),
    .ADDR    (ADDR),
    .DAT_O   (DAT_O),
    .DAT_I   (DAT_I),
    .ACK     (ACK),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter model and scoreboard pop
  initial begin
    logic [7:0] got;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        got = tx_data;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: got %02h, required no byte", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL tx_byte: got %02h, required %02h", got, e);
          end
        end
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_data !== got) begin
          n_err++;
          $display("FAIL tx_hold: got %02h, required %02h", tx_data, got);
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Wishbone slave: ACK on the ack_delay-th STB cycle (0 = never)
  initial begin
    forever begin
      @(negedge clk);
      if (ACK) begin
        ACK = 1'b0;
      end else if (STB === 1'b1) begin
        scnt++;
        if ((ack_delay != 0) && (scnt == ack_delay)) begin
          ACK   = 1'b1;
          DAT_I = rd_data;
        end
      end else begin
        scnt = 0;
      end
    end
  end

  // STB monitor
  initial begin
    forever begin
      @(negedge clk);
      if (STB === 1'b1) begin
        stb_cycles++;
        if (!stb_prev) begin
          stb_pulses++;
          cap_we   = WE;
          cap_addr = ADDR;
          cap_dat  = DAT_O;
        end
      end
      stb_prev = (STB === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    stb_cycles = 0;
    stb_pulses = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] f, input int n);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = f[8*(n-1-i) +: 8];
      x = x ^ b;
      send_byte(b);
    end
`ifdef WB_BRIDGE_CKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic push_reply(input logic [31:0] r, input int n);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = r[8*(n-1-i) +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
`ifdef WB_BRIDGE_CKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((busy === 1'b0) && (exp_q.size() == 0) && (tx_busy === 1'b0) && (STB === 1'b0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (STB !== 1'b0 || WE !== 1'b0) begin
      n_err++; $display("FAIL reset_stb: STB=%b WE=%b, required 0 0", STB, WE);
    end
    n_cmp++;
    if (busy !== 1'b0 || tx_en !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: busy=%b tx_en=%b, required 0 0", busy, tx_en);
    end
    n_cmp++;
    if (err_cnt !== 8'h00) begin
      n_err++; $display("FAIL reset_err: got %02h, required 00", err_cnt);
    end
    n_cmp++;
    if (ADDR !== 32'h0 || DAT_O !== 32'h0 || tx_data !== 8'h00) begin
      n_err++; $display("FAIL reset_data: ADDR=%08h DAT_O=%08h tx_data=%02h, required zeros", ADDR, DAT_O, tx_data);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    clear_mon();
    ack_delay = 2;
    push_reply(32'h4B, 1);
    send_frame(72'h57_00001004_DEADBEEF, 9);
    n_cmp++;
    if (STB !== 1'b1) begin
      n_err++; $display("FAIL wr_latency: STB=%b one cycle after last byte, required 1", STB);
    end
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL wr_done: bridge still busy or %0d bytes unsent, required idle", exp_q.size());
    end
    n_cmp++;
    if (stb_pulses != 1 || cap_we !== 1'b1) begin
      n_err++; $display("FAIL wr_stb: pulses=%0d WE=%b, required 1 1", stb_pulses, cap_we);
    end
    n_cmp++;
    if (cap_addr !== 32'h00001004 || cap_dat !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_bus: ADDR=%08h DAT_O=%08h, required 00001004 DEADBEEF", cap_addr, cap_dat);
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_mon();
    ack_delay = 3;
    rd_data = 32'h12345678;
    push_reply(32'h12345678, 4);
    send_frame({32'h0, 40'h52_00000008}, 5);
    n_cmp++;
    if (STB !== 1'b1) begin
      n_err++; $display("FAIL rd_latency: STB=%b, required 1", STB);
    end
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rd_done: %0d bytes unsent, required idle", exp_q.size());
    end
    n_cmp++;
    if (stb_pulses != 1 || cap_we !== 1'b0 || cap_addr !== 32'h00000008) begin
      n_err++; $display("FAIL rd_bus: pulses=%0d WE=%b ADDR=%08h, required 1 0 00000008", stb_pulses, cap_we, cap_addr);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    ack_delay = 0;
    exp_err++;
    push_reply(32'hEE, 1);
    send_frame({32'h0, 40'h52_00000020}, 5);
    wait_quiet(4000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL tmo_done: %0d bytes unsent, required idle", exp_q.size());
    end
    n_cmp++;
    if (stb_cycles != 1024) begin
      n_err++; $display("FAIL tmo_stb_len: got %0d cycles, required 1024", stb_cycles);
    end
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL tmo_err: got %0d, required %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_ack_at_timeout();
    bit ok;
    clear_mon();
    ack_delay = 1024;
    rd_data = 32'hA5C3_0F96;
    push_reply(32'hA5C30F96, 4);
    send_frame({32'h0, 40'h52_00000103}, 5);
    wait_quiet(4000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL ackedge_done: %0d bytes unsent, required idle", exp_q.size());
    end
    n_cmp++;
    if (stb_cycles != 1024 || err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL ackedge: stb=%0d err=%0d, required 1024 %0d", stb_cycles, err_cnt, exp_err);
    end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    clear_mon();
    exp_err++;
    push_reply(32'h3F, 1);
    send_byte(8'h41);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || stb_pulses != 0) begin
      n_err++; $display("FAIL bad_op: ok=%0d pulses=%0d, required 1 0", ok, stb_pulses);
    end
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL bad_op_err: got %0d, required %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_drop_and_stray_ack();
    bit ok;
    clear_mon();
    @(negedge clk);
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || STB !== 1'b0) begin
      n_err++; $display("FAIL stray_ack: busy=%b STB=%b, required 0 0", busy, STB);
    end
    ack_delay = 20;
    rd_data = 32'hCAFEF00D;
    push_reply(32'hCAFEF00D, 4);
    send_frame({32'h0, 40'h52_00000044}, 5);
    send_byte(8'h41);
    send_byte(8'h57);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || stb_pulses != 1 || err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL rx_drop: ok=%0d pulses=%0d err=%0d, required 1 1 %0d", ok, stb_pulses, err_cnt, exp_err);
    end
  endtask

`ifdef WB_BRIDGE_CKSUM_EN
  task automatic test_cksum();
    bit ok;
    clear_mon();
    exp_err++;
    push_reply(32'h3F, 1);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || stb_pulses != 0 || err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL cksum_bad: ok=%0d pulses=%0d err=%0d, required 1 0 %0d", ok, stb_pulses, err_cnt, exp_err);
    end
    clear_mon();
    ack_delay = 3;
    rd_data = 32'h12345678;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    exp_q.push_back(8'h78); exp_q.push_back(8'h08);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h52);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || stb_pulses != 1) begin
      n_err++; $display("FAIL cksum_good: ok=%0d pulses=%0d, required 1 1", ok, stb_pulses);
    end
  endtask
`endif

  task automatic test_err_saturate();
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    while (exp_err < 255) begin
      exp_err++;
      push_reply(32'h3F, 1);
      send_byte(8'h41);
      wait_quiet(200, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_cmp++;
    if (!all_ok || err_cnt !== 8'hFF) begin
      n_err++; $display("FAIL err_fill: ok=%0d err=%02h, required 1 FF", all_ok, err_cnt);
    end
    push_reply(32'h3F, 1);
    send_byte(8'h41);
    wait_quiet(200, ok);
    n_cmp++;
    if (!ok || err_cnt !== 8'hFF) begin
      n_err++; $display("FAIL err_sat: ok=%0d err=%02h, required 1 FF", ok, err_cnt);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit ok;
    clear_mon();
    ack_delay = 0;
    send_frame({32'h0, 40'h52_00000010}, 5);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (STB !== 1'b1) begin
      n_err++; $display("FAIL midbus_stb_pre: STB=%b, required 1", STB);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (STB !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00) begin
      n_err++; $display("FAIL midbus_reset: STB=%b busy=%b err=%02h, required 0 0 00", STB, busy, err_cnt);
    end
    exp_err = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    clear_mon();
    ack_delay = 2;
    push_reply(32'h4B, 1);
    send_frame(72'h57_00000003_01020304, 9);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || stb_pulses != 1 || cap_addr !== 32'h00000003 || cap_dat !== 32'h01020304) begin
      n_err++; $display("FAIL post_reset_wr: ok=%0d pulses=%0d ADDR=%08h DAT_O=%08h, required 1 1 00000003 01020304", ok, stb_pulses, cap_addr, cap_dat);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_timeout();
    test_bad_opcode();
    test_drop_and_stray_ack();
`ifdef WB_BRIDGE_CKSUM_EN
    test_cksum();
`endif
    test_err_saturate();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
